// File: rtl/jtag_tap_ctrl.sv
// ---------------------------------------------------------------------------
// JtagTapCtrl -- IEEE 1149.1 TAP controller plus instruction register.
//
// Runs the 16-state TAP state machine from tms and decodes the DR strobes
// from the registered state. It also holds the instruction register, turns
// the current instruction into boundary-scan controls and a DR select, and
// drives the IR or DR serial stream onto tdo one cycle late.
//
// Ports
//   tck                 sole clock, everything changes on the rising edge
//   reset               synchronous active-high, forces Test-Logic-Reset
//   tms, tdi            TAP mode select and serial data in
//   dr_tdo_byp/id/bsr   serial outputs of the bypass, ID and boundary regs
//   clkDR, captureDR,
//   shiftDR, updateDR   DR control strobes (Moore, from registered state)
//   mode, enableIn,
//   enableOut,
//   bsr_reset           boundary-scan register controls
//   sel_dr              00 bypass, 01 idcode, 10 boundary scan
//   tdo, tdo_en         registered serial out and its shift qualifier
// ---------------------------------------------------------------------------
module jtag_tap_ctrl #(
    parameter int IR_LEN = 4
) (
    input  logic       tck,
    input  logic       reset,
    input  logic       tms,
    input  logic       tdi,
    input  logic       dr_tdo_byp,
    input  logic       dr_tdo_id,
    input  logic       dr_tdo_bsr,
    output logic       clkDR,
    output logic       captureDR,
    output logic       shiftDR,
    output logic       updateDR,
    output logic       mode,
    output logic       enableIn,
    output logic       enableOut,
    output logic       bsr_reset,
    output logic [1:0] sel_dr,
    output logic       tdo,
    output logic       tdo_en
);

    typedef enum logic [3:0] {
        TLR, RTI,
        SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
    } tapState_e;

    // Every opcode not listed here, all-ones included, decodes as bypass.
    localparam logic [IR_LEN-1:0] OP_EXTEST = '0;
    localparam logic [IR_LEN-1:0] OP_SAMPLE = IR_LEN'(1);
    localparam logic [IR_LEN-1:0] OP_IDCODE = IR_LEN'(2);

    tapState_e         state_q, state_d;
    logic [IR_LEN-1:0] ir_q, ir_d;
    logic [IR_LEN-1:0] irShift_q, irShift_d;
    logic              tdo_q, tdo_d;
    logic              tdoEn_q, tdoEn_d;
    logic [1:0]        selDr;
    logic              isExtest, isSample, isIdcode;

    // State and datapath registers; reset discards any half-shifted opcode.
    always_ff @(posedge tck) begin
        if (reset) begin
            state_q   <= TLR;
            ir_q      <= OP_IDCODE;
            irShift_q <= '0;
            tdo_q     <= 1'b0;
            tdoEn_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            irShift_q <= irShift_d;
            tdo_q     <= tdo_d;
            tdoEn_q   <= tdoEn_d;
        end
    end

    // TAP next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            TLR:    state_d = tms ? TLR    : RTI;
            RTI:    state_d = tms ? SEL_DR : RTI;
            SEL_DR: state_d = tms ? SEL_IR : CAP_DR;
            CAP_DR: state_d = tms ? EX1_DR : SH_DR;
            SH_DR:  state_d = tms ? EX1_DR : SH_DR;
            EX1_DR: state_d = tms ? UPD_DR : PAU_DR;
            PAU_DR: state_d = tms ? EX2_DR : PAU_DR;
            EX2_DR: state_d = tms ? UPD_DR : SH_DR;
            UPD_DR: state_d = tms ? SEL_DR : RTI;
            SEL_IR: state_d = tms ? TLR    : CAP_IR;
            CAP_IR: state_d = tms ? EX1_IR : SH_IR;
            SH_IR:  state_d = tms ? EX1_IR : SH_IR;
            EX1_IR: state_d = tms ? UPD_IR : PAU_IR;
            PAU_IR: state_d = tms ? EX2_IR : PAU_IR;
            EX2_IR: state_d = tms ? UPD_IR : SH_IR;
            UPD_IR: state_d = tms ? SEL_DR : RTI;
            default: state_d = TLR;
        endcase
    end

    // IR datapath: capture the fixed 0..01 pattern, shift LSB first,
    // commit on Update-IR, and fall back to IDCODE in Test-Logic-Reset.
    always_comb begin
        ir_d      = ir_q;
        irShift_d = irShift_q;
        unique case (state_q)
            CAP_IR: irShift_d = IR_LEN'(1);
            SH_IR:  irShift_d = {tdi, irShift_q[IR_LEN-1:1]};
            UPD_IR: ir_d      = irShift_q;
            TLR:    ir_d      = OP_IDCODE;
            default: ;
        endcase
    end

    // Serial out: tdo holds its last value outside the shift states so a
    // slow sampler never sees a glitch between scans.
    always_comb begin
        tdo_d   = tdo_q;
        tdoEn_d = 1'b0;
        if (state_q == SH_IR) begin
            tdo_d   = irShift_q[0];
            tdoEn_d = 1'b1;
        end else if (state_q == SH_DR) begin
            tdoEn_d = 1'b1;
            unique case (selDr)
                2'b00:   tdo_d = dr_tdo_byp;
                2'b01:   tdo_d = dr_tdo_id;
                default: tdo_d = dr_tdo_bsr;
            endcase
        end
    end

    // Instruction decode depends on ir only, so it settles one edge after
    // Update-IR and never follows the partial contents of the shift reg.
    always_comb begin
        isExtest = (ir_q == OP_EXTEST);
        isSample = (ir_q == OP_SAMPLE);
        isIdcode = (ir_q == OP_IDCODE);
        selDr    = 2'b00;
        if (isExtest || isSample) begin
            selDr = 2'b10;
        end else if (isIdcode) begin
            selDr = 2'b01;
        end
    end

    assign clkDR     = (state_q == CAP_DR) || (state_q == SH_DR);
    assign captureDR = (state_q == CAP_DR);
    assign shiftDR   = (state_q == SH_DR);
    assign updateDR  = (state_q == UPD_DR);
    assign mode      = isExtest;
    assign enableIn  = isExtest || isSample;
    assign enableOut = (state_q != TLR);
    assign bsr_reset = (state_q != TLR);
    assign sel_dr    = selDr;
    assign tdo       = tdo_q;
    assign tdo_en    = tdoEn_q;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// ---------------------------------------------------------------------------
// TbJtagTapCtrl -- directed bench for jtag_tap_ctrl.
//
// Stimulus tasks walk the TAP through IR and DR scans and push the tdo bits
// they expect into a queue; an independent monitor pops one entry for every
// cycle the DUT raises tdo_en. Strobes and decoded controls are compared
// directly against hand-computed constants after each step.
// ---------------------------------------------------------------------------
module tb_jtag_tap_ctrl;

    logic       tck = 1'b0;
    logic       reset;
    logic       tms;
    logic       tdi;
    logic       drTdoByp;
    logic       drTdoId;
    logic       drTdoBsr;
    logic       clkDR;
    logic       captureDR;
    logic       shiftDR;
    logic       updateDR;
    logic       mode;
    logic       enableIn;
    logic       enableOut;
    logic       bsrReset;
    logic [1:0] selDr;
    logic       tdo;
    logic       tdoEn;

    int testsRun    = 0;
    int testsFailed = 0;
    bit expTdoQ[$];

    jtag_tap_ctrl #(.IR_LEN(4)) dut (
        .tck        (tck),
        .reset      (reset),
        .tms        (tms),
        .tdi        (tdi),
        .dr_tdo_byp (drTdoByp),
        .dr_tdo_id  (drTdoId),
        .dr_tdo_bsr (drTdoBsr),
        .clkDR      (clkDR),
        .captureDR  (captureDR),
        .shiftDR    (shiftDR),
        .updateDR   (updateDR),
        .mode       (mode),
        .enableIn   (enableIn),
        .enableOut  (enableOut),
        .bsr_reset  (bsrReset),
        .sel_dr     (selDr),
        .tdo        (tdo),
        .tdo_en     (tdoEn)
    );

    always #5 tck = ~tck;

    // Scoreboard monitor: every cycle the DUT claims tdo is valid, the
    // oldest expected bit must be waiting and must match.
    initial begin
        forever begin
            @(negedge tck);
            if (tdoEn === 1'b1) begin
                testsRun++;
                if (expTdoQ.size() == 0) begin
                    testsFailed++;
                    $display("[TB] FAIL tdo_unexpected: tdo_en high with tdo=%0b, expected no output", tdo);
                end else begin
                    bit expBit;
                    expBit = expTdoQ.pop_front();
                    if (tdo !== expBit) begin
                        testsFailed++;
                        $display("[TB] FAIL tdo_scoreboard: got %0b, expected %0b", tdo, expBit);
                    end
                end
            end
        end
    end

    // Drive one TAP cycle; inputs settle 1 time unit after the edge so the
    // next rising edge samples them and the caller can check straight away.
    task automatic applyStimulus(input logic tmsV, input logic tdiV);
        tms = tmsV;
        tdi = tdiV;
        @(posedge tck);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
        end
    endtask

    // Strobe vector is {clkDR, captureDR, shiftDR, updateDR}.
    task automatic checkStrobes(input string name, input logic [3:0] exp);
        checkOutput(name, {4'b0, clkDR, captureDR, shiftDR, updateDR}, {4'b0, exp});
    endtask

    // Decode vector is {mode, enableIn, enableOut, bsr_reset, sel_dr[1:0]}.
    task automatic checkDecode(input string name, input logic [5:0] exp);
        checkOutput(name, {2'b0, mode, enableIn, enableOut, bsrReset, selDr}, {2'b0, exp});
    endtask

    // From RTI: full IR scan of 'value', ending back in RTI. The captured
    // 0001 pattern is what comes out of tdo, LSB first.
    task automatic loadIr(input logic [3:0] value);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        expTdoQ.push_back(1'b1);
        expTdoQ.push_back(1'b0);
        expTdoQ.push_back(1'b0);
        expTdoQ.push_back(1'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(i == 3, value[i]);
        end
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
    endtask

    task automatic driveDrBit(input logic b, input logic [1:0] sel);
        drTdoByp = (sel == 2'b00) ? b : ~b;
        drTdoId  = (sel == 2'b01) ? b : ~b;
        drTdoBsr = (sel == 2'b10) ? b : ~b;
        expTdoQ.push_back(b);
    endtask

    // From RTI: DR scan of 4 bits with a pause excursion in the middle.
    // Only the register named by 'sel' carries the pattern; the others
    // carry its inverse so a wrong mux choice shows up on tdo.
    task automatic scanDr(input logic [3:0] pattern, input logic [1:0] sel);
        applyStimulus(1'b1, 1'b0);
        checkStrobes("strobe_seldr", 4'b0000);
        applyStimulus(1'b0, 1'b0);
        checkStrobes("strobe_capdr", 4'b1100);
        applyStimulus(1'b0, 1'b0);
        checkStrobes("strobe_shdr", 4'b1010);
        driveDrBit(pattern[0], sel);
        applyStimulus(1'b0, 1'b0);
        driveDrBit(pattern[1], sel);
        applyStimulus(1'b1, 1'b0);
        checkStrobes("strobe_ex1dr", 4'b0000);
        applyStimulus(1'b0, 1'b0);
        checkStrobes("strobe_paudr", 4'b0000);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        checkStrobes("strobe_ex2dr", 4'b0000);
        applyStimulus(1'b0, 1'b0);
        checkStrobes("strobe_shdr_again", 4'b1010);
        driveDrBit(pattern[2], sel);
        applyStimulus(1'b0, 1'b0);
        driveDrBit(pattern[3], sel);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        checkStrobes("strobe_upddr", 4'b0001);
        applyStimulus(1'b0, 1'b0);
        checkStrobes("strobe_rti_after_upd", 4'b0000);
    endtask

    initial begin
        reset    = 1'b1;
        tms      = 1'b1;
        tdi      = 1'b0;
        drTdoByp = 1'b0;
        drTdoId  = 1'b0;
        drTdoBsr = 1'b0;

        // Reset state: TLR with IDCODE loaded.
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        checkStrobes("reset_strobes", 4'b0000);
        checkDecode("reset_decode", 6'b000001);
        checkOutput("reset_tdo", {6'b0, tdo, tdoEn}, 8'h00);
        reset = 1'b0;

        // IDCODE DR scan: tdo follows dr_tdo_id one cycle late.
        applyStimulus(1'b0, 1'b0);
        checkDecode("rti_decode_idcode", 6'b001101);
        scanDr(4'b1101, 2'b01);

        // IR scan of all ones -> BYPASS.
        loadIr(4'hF);
        checkDecode("ir_bypass_decode", 6'b001100);
        scanDr(4'b0110, 2'b00);

        // Undefined opcode decodes as bypass.
        loadIr(4'h6);
        checkDecode("ir_undef_decode", 6'b001100);

        // EXTEST then SAMPLE.
        loadIr(4'h0);
        checkDecode("ir_extest_decode", 6'b111110);
        scanDr(4'b1001, 2'b10);
        loadIr(4'h1);
        checkDecode("ir_sample_decode", 6'b011110);

        // Five tms=1 edges from Shift-DR reach TLR; ir reloads one edge later.
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkStrobes("shdr_before_tlr", 4'b1010);
        drTdoByp = 1'b0;
        drTdoId  = 1'b0;
        drTdoBsr = 1'b1;
        expTdoQ.push_back(1'b1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b0);
        end
        checkStrobes("tlr_strobes", 4'b0000);
        checkDecode("tlr_entry_decode", 6'b010010);
        applyStimulus(1'b1, 1'b0);
        checkDecode("tlr_ir_idcode", 6'b000001);

        // Reset in the middle of an IR scan discards the partial opcode.
        applyStimulus(1'b0, 1'b0);
        loadIr(4'hF);
        checkDecode("pre_abort_bypass", 6'b001100);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        expTdoQ.push_back(1'b1);
        expTdoQ.push_back(1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0);
        reset = 1'b0;
        checkDecode("abort_decode", 6'b000001);
        checkOutput("abort_tdo", {6'b0, tdo, tdoEn}, 8'h00);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkDecode("abort_no_partial_ir", 6'b001101);

        // All expected serial bits must have been consumed.
        applyStimulus(1'b0, 1'b0);
        checkOutput("scoreboard_drained", 8'(expTdoQ.size()), 8'h00);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
